// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the EX-stage forwarding / hazard logic.
//   - operand mux select codes and the hard-wired zero register
//   - scoreboard entry layout {valid, dest, reg_write, mem_read}
//   - fwd_pick(): nearest-producer select for one ALU operand
package mips_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_REG   = 2'b00;  // register file
    localparam logic [1:0] FWD_EXMEM = 2'b01;  // EX/MEM result
    localparam logic [1:0] FWD_MEMWB = 2'b10;  // MEM/WB result

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              reg_write;
        logic              mem_read;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    // The younger producer (EX) wins over the older one (MEM). WB is never
    // consulted: the register file writes through to the ID read.
    function automatic logic [1:0] fwd_pick(input logic              in_use,
                                            input logic [REG_AW-1:0] src,
                                            input sb_entry_t         ex,
                                            input sb_entry_t         mem);
        logic [1:0] sel;
        sel = FWD_REG;
        if (in_use && src != REG_ZERO) begin
            if (ex.valid && ex.reg_write && ex.dest == src)
                sel = FWD_EXMEM;
            else if (mem.valid && mem.reg_write && mem.dest == src)
                sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sb_stage_reg.sv
// sb_stage_reg: one scoreboard entry register.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   hold_i     : keep the current entry (pipeline frozen)
//   load_i     : capture d_i; when low the stage takes a bubble
//   d_i / q_o  : incoming / held scoreboard entry
module sb_stage_reg
    import mips_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      hold_i,
    input  logic      load_i,
    input  sb_entry_t d_i,
    output sb_entry_t q_o
);

    sb_entry_t q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (!hold_i)
            q_d = load_i ? d_i : SB_BUBBLE;
    end

    always_ff @(posedge clk) begin
        if (reset) q_q <= SB_BUBBLE;
        else       q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand-forwarding selects and load-use stall for the
// EX stage of a 5-stage MIPS pipeline.
//   clk, reset                  : rising-edge clock, synchronous active-high reset
//   id_valid/rs/rt/uses_rs/rt   : ID-stage instruction and its source operands
//   id_dest/reg_write/mem_read  : ID-stage destination info for the scoreboard
//   freeze                      : global hold, all state keeps its value
//   flush                       : kill the ID instruction (becomes a bubble)
//   fwd_a_sel, fwd_b_sel        : registered ALU operand mux selects
//   stall                       : combinational load-use stall request
//   stall_cnt                   : saturating count of stalls taken
module fwd_hazard_unit
    import mips_pkg::*;
#(
    parameter int REG_AW = mips_pkg::REG_AW,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              freeze,
    input  logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    sb_entry_t ex_q, mem_q, wb_q, id_ent;
    logic      hazard, take;

    logic [1:0]       sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign id_ent = '{valid: 1'b1, dest: id_dest,
                      reg_write: id_reg_write, mem_read: id_mem_read};

    // A load still in EX has no data yet; a consumer in ID must wait one cycle.
    assign hazard = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.dest != REG_ZERO)
                 && ((id_uses_rs && ex_q.dest == id_rs) ||
                     (id_uses_rt && ex_q.dest == id_rt));

    assign stall = hazard && !flush && !freeze;

    // ID instruction actually moves into EX on this edge.
    assign take = id_valid && !stall && !flush;

    sb_stage_reg u_sb_ex (
        .clk(clk), .reset(reset), .hold_i(freeze), .load_i(take),
        .d_i(id_ent), .q_o(ex_q));

    sb_stage_reg u_sb_mem (
        .clk(clk), .reset(reset), .hold_i(freeze), .load_i(1'b1),
        .d_i(ex_q), .q_o(mem_q));

    sb_stage_reg u_sb_wb (
        .clk(clk), .reset(reset), .hold_i(freeze), .load_i(1'b1),
        .d_i(mem_q), .q_o(wb_q));

    // WB is tracked for pipeline visibility only; it never forwards.
    logic unused_wb;
    assign unused_wb = ^wb_q;

    always_comb begin
        sel_a_d = FWD_REG;
        sel_b_d = FWD_REG;
        if (take) begin
            sel_a_d = fwd_pick(id_uses_rs, id_rs, ex_q, mem_q);
            sel_b_d = fwd_pick(id_uses_rt, id_rt, ex_q, mem_q);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_a_q <= FWD_REG;
            sel_b_q <= FWD_REG;
            cnt_q   <= '0;
        end else if (!freeze) begin
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fwd_a_sel = sel_a_q;
    assign fwd_b_sel = sel_b_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed instruction sequences with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural pipeline model.
module tb_fwd_hazard_unit;

    localparam int REG_AW  = 5;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs, id_rt, id_dest;
    logic              id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
    logic              freeze, flush;
    logic [1:0]        fwd_a_sel, fwd_b_sel;
    logic              stall;
    logic [CNT_W-1:0]  stall_cnt;

    fwd_hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .freeze(freeze), .flush(flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall(stall), .stall_cnt(stall_cnt));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit armed = 0;

    // ---------------- behavioural model ----------------
    // Pipeline slots after ID: index 0 = EX, 1 = MEM, 2 = WB.
    bit mv[3];
    int md[3];
    bit mrw[3];
    bit mmr[3];
    int msa, msb, mcnt;

    function automatic bit m_stall();
        if (!id_valid || flush || freeze) return 0;
        if (!(mv[0] && mmr[0] && md[0] != 0)) return 0;
        return (id_uses_rs && md[0] == int'(id_rs)) || (id_uses_rt && md[0] == int'(id_rt));
    endfunction

    function automatic bit m_take();
        return id_valid && !m_stall() && !flush;
    endfunction

    // Closest earlier writer among EX and MEM supplies the operand.
    function automatic int m_src(bit used, int src);
        if (!used || src == 0) return 0;
        for (int s = 0; s < 2; s++)
            if (mv[s] && mrw[s] && md[s] == src) return s + 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                mv[i] <= 0; md[i] <= 0; mrw[i] <= 0; mmr[i] <= 0;
            end
            msa <= 0; msb <= 0; mcnt <= 0;
        end else if (!freeze) begin
            if (m_stall() && mcnt != CNT_MAX) mcnt <= mcnt + 1;
            msa <= m_take() ? m_src(id_uses_rs, int'(id_rs)) : 0;
            msb <= m_take() ? m_src(id_uses_rt, int'(id_rt)) : 0;
            for (int i = 2; i > 0; i--) begin
                mv[i] <= mv[i-1]; md[i] <= md[i-1]; mrw[i] <= mrw[i-1]; mmr[i] <= mmr[i-1];
            end
            mv[0]  <= m_take();
            md[0]  <= m_take() ? int'(id_dest) : 0;
            mrw[0] <= m_take() && id_reg_write;
            mmr[0] <= m_take() && id_mem_read;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, got, exp);
        end
    endtask

    // Single compare process against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("model fwd_a_sel", 32'(fwd_a_sel), 32'(msa));
            chk("model fwd_b_sel", 32'(fwd_b_sel), 32'(msb));
            chk("model stall",     32'(stall),     32'(m_stall()));
            chk("model stall_cnt", 32'(stall_cnt), 32'(mcnt));
        end
    end

    // ---------------- stimulus ----------------
    // Present an instruction in ID just after a rising edge; the next edge consumes it.
    task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                         input int dest, input bit rw, input bit mr,
                         input bit fl = 0, input bit fz = 0);
        @(posedge clk);
        #2;
        id_valid = v; id_rs = REG_AW'(rs); id_rt = REG_AW'(rt);
        id_uses_rs = urs; id_uses_rt = urt; id_dest = REG_AW'(dest);
        id_reg_write = rw; id_mem_read = mr; flush = fl; freeze = fz;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        repeat (3) nop();
    endtask

    initial begin
        // Reset with random inputs on the bus.
        @(negedge clk);
        reset = 1;
        id_valid = 1'($urandom); id_rs = REG_AW'($urandom); id_rt = REG_AW'($urandom);
        id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom); id_dest = REG_AW'($urandom);
        id_reg_write = 1'($urandom); id_mem_read = 1'($urandom);
        freeze = 1'($urandom); flush = 1'($urandom);
        repeat (2) @(posedge clk);
        #2;
        reset = 0;
        id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_reg_write = 0; id_mem_read = 0;
        freeze = 0; flush = 0;
        armed = 1;
        @(negedge clk);
        chk("reset fwd_a_sel", 32'(fwd_a_sel), 0);
        chk("reset fwd_b_sel", 32'(fwd_b_sel), 0);
        chk("reset stall",     32'(stall),     0);
        chk("reset stall_cnt", 32'(stall_cnt), 0);

        // add $3 ; sub $5,$3,$4
        drain();
        drive(1, 1, 2, 1, 1, 3, 1, 0);
        drive(1, 3, 4, 1, 1, 5, 1, 0);
        nop(); @(negedge clk);
        chk("ex fwd a", 32'(fwd_a_sel), 1);
        chk("ex fwd b", 32'(fwd_b_sel), 0);

        // add $3 ; nop ; or $6,$3,$3
        drain();
        drive(1, 1, 2, 1, 1, 3, 1, 0);
        nop();
        drive(1, 3, 3, 1, 1, 6, 1, 0);
        nop(); @(negedge clk);
        chk("mem fwd a", 32'(fwd_a_sel), 2);
        chk("mem fwd b", 32'(fwd_b_sel), 2);

        // add $3 ; add $3 ; and $7,$3,$2
        drain();
        drive(1, 1, 2, 1, 1, 3, 1, 0);
        drive(1, 1, 2, 1, 1, 3, 1, 0);
        drive(1, 3, 2, 1, 1, 7, 1, 0);
        nop(); @(negedge clk);
        chk("priority a", 32'(fwd_a_sel), 1);
        chk("priority b", 32'(fwd_b_sel), 0);

        // lw $8 ; add $9,$8,$1 (re-presented while stalled)
        drain();
        drive(1, 1, 0, 1, 0, 8, 1, 1);
        drive(1, 8, 1, 1, 1, 9, 1, 0);
        @(negedge clk);
        chk("load-use stall", 32'(stall), 1);
        drive(1, 8, 1, 1, 1, 9, 1, 0);
        @(negedge clk);
        chk("load-use one cycle", 32'(stall), 0);
        chk("load-use count",     32'(stall_cnt), 1);
        nop(); @(negedge clk);
        chk("load-use fwd a", 32'(fwd_a_sel), 2);

        // $0 writer/load then $0 reader
        drain();
        drive(1, 1, 2, 1, 1, 0, 1, 1);
        drive(1, 0, 0, 1, 1, 4, 1, 0);
        @(negedge clk);
        chk("zero no stall", 32'(stall), 0);
        nop(); @(negedge clk);
        chk("zero fwd a", 32'(fwd_a_sel), 0);
        chk("zero fwd b", 32'(fwd_b_sel), 0);

        // lw $8 ; add $9,$8 flushed ; or reads $9 -> must not see the flushed add
        drain();
        drive(1, 1, 0, 1, 0, 8, 1, 1);
        drive(1, 8, 1, 1, 1, 9, 1, 0, 1);
        @(negedge clk);
        chk("flush no stall", 32'(stall), 0);
        drive(1, 9, 9, 1, 1, 10, 1, 0);
        nop(); @(negedge clk);
        chk("flush bubble a", 32'(fwd_a_sel), 0);
        chk("flush count",    32'(stall_cnt), 1);

        // add $3 ; sub $5,$3,$4 ; freeze 3 edges ; or $6,$5,$5
        drain();
        drive(1, 1, 2, 1, 1, 3, 1, 0);
        drive(1, 3, 4, 1, 1, 5, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 5, 5, 1, 1, 6, 1, 0, 0, 1);
            @(negedge clk);
            chk("freeze hold a",   32'(fwd_a_sel), 1);
            chk("freeze hold cnt", 32'(stall_cnt), 1);
        end
        drive(1, 5, 5, 1, 1, 6, 1, 0);
        nop(); @(negedge clk);
        chk("resume fwd a", 32'(fwd_a_sel), 1);
        chk("resume fwd b", 32'(fwd_b_sel), 1);

        // Randomized traffic over a tiny register set to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #2;
            reset        = ($urandom_range(0, 99) == 0);
            id_valid     = ($urandom_range(0, 9) != 0);
            id_rs        = REG_AW'($urandom_range(0, 3));
            id_rt        = REG_AW'($urandom_range(0, 3));
            id_uses_rs   = 1'($urandom);
            id_uses_rt   = 1'($urandom);
            id_dest      = REG_AW'($urandom_range(0, 3));
            id_reg_write = ($urandom_range(0, 3) != 0);
            id_mem_read  = ($urandom_range(0, 2) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            freeze       = ($urandom_range(0, 9) == 0);
        end
        @(posedge clk);
        #2;
        reset = 0; freeze = 0; flush = 0;
        drain();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
